// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage data-memory unit: lane steering, bus handshake with timeout,
// alignment checking and LL/SC reservation tracking. All outputs are registered.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [3:0]            op_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [4:0]            waddr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_W/8-1:0]   bus_sel_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  wb_we_o,
  output logic [4:0]            wb_waddr_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic [1:0]            exc_o,
  output logic [ADDR_W-1:0]     exc_addr_o
);

  localparam int unsigned LANES   = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(LANES);
  localparam bit          WIDE    = (DATA_W == 64);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d, wr_q, wr_d, ll_q, ll_d, sc_q, sc_d;
  logic              flushed_q, flushed_d, llbit_q, llbit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-3:0] resv_q, resv_d;

  logic                stall_d, bus_req_d, bus_we_d, wb_we_d;
  logic [LANES-1:0]    bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_d, exc_addr_d;
  logic [DATA_W-1:0]   bus_wdata_d, wb_wdata_d;
  logic [4:0]          wb_waddr_d;
  logic [1:0]          exc_d;

  // Opcode decode; ops needing a 64-bit bus are dropped as NOPs on a 32-bit bus
  logic       dec_legal, dec_load, dec_store, dec_signed, dec_ll, dec_sc;
  logic [1:0] dec_size;
  always_comb begin
    dec_legal  = 1'b1;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_signed = 1'b0;
    dec_ll     = 1'b0;
    dec_sc     = 1'b0;
    dec_size   = 2'd0;
    case (op_i)
      4'd1:    begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd0; end
      4'd2:    begin dec_load = 1'b1; dec_size = 2'd0; end
      4'd3:    begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd1; end
      4'd4:    begin dec_load = 1'b1; dec_size = 2'd1; end
      4'd5:    begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 2'd2; end
      4'd6:    begin dec_load = 1'b1; dec_size = 2'd2; dec_legal = WIDE; end
      4'd7:    begin dec_load = 1'b1; dec_size = 2'd3; dec_legal = WIDE; end
      4'd8:    begin dec_store = 1'b1; dec_size = 2'd0; end
      4'd9:    begin dec_store = 1'b1; dec_size = 2'd1; end
      4'd10:   begin dec_store = 1'b1; dec_size = 2'd2; end
      4'd11:   begin dec_store = 1'b1; dec_size = 2'd3; dec_legal = WIDE; end
      4'd12:   begin dec_load = 1'b1; dec_signed = 1'b1; dec_ll = 1'b1; dec_size = 2'd2; end
      4'd13:   begin dec_store = 1'b1; dec_sc = 1'b1; dec_size = 2'd2; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Request-side lane mask (lane 0 = MSB) and replicated store data
  logic [2:0]        amask;
  logic              misal;
  logic [OFF_W-1:0]  off;
  int unsigned       nb, sh;
  logic [LANES-1:0]  sel;
  logic [DATA_W-1:0] rep;
  always_comb begin
    amask = 3'((32'd1 << dec_size) - 32'd1);
    misal = |(addr_i[2:0] & amask);
    off   = addr_i[OFF_W-1:0];
    nb    = 32'd1 << dec_size;
    sh    = LANES - nb - 32'(off);
    sel   = ~({LANES{1'b1}} << nb) << sh;
    case (dec_size)
      2'd0:    rep = {LANES{wdata_i[7:0]}};
      2'd1:    rep = {(LANES/2){wdata_i[15:0]}};
      2'd2:    rep = {(LANES/4){wdata_i[31:0]}};
      default: rep = wdata_i;
    endcase
  end

  // Response-side lane extraction and extension
  int unsigned       nbq, shq;
  logic [DATA_W-1:0] rsh, ext;
  always_comb begin
    nbq = 32'd1 << size_q;
    shq = LANES - nbq - 32'(addr_q[OFF_W-1:0]);
    rsh = bus_rdata_i >> (8 * shq);
    case (size_q)
      2'd0:    ext = signed_q ? DATA_W'($signed(rsh[7:0]))  : DATA_W'(rsh[7:0]);
      2'd1:    ext = signed_q ? DATA_W'($signed(rsh[15:0])) : DATA_W'(rsh[15:0]);
      2'd2:    ext = signed_q ? DATA_W'($signed(rsh[31:0])) : DATA_W'(rsh[31:0]);
      default: ext = rsh;
    endcase
  end

  logic resv_match;
  assign resv_match = (addr_i[ADDR_W-1:2] == resv_q);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wr_d        = wr_q;
    ll_d        = ll_q;
    sc_d        = sc_q;
    flushed_d   = flushed_q;
    addr_d      = addr_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    llbit_d     = llbit_q;
    resv_d      = resv_q;
    bus_req_d   = bus_req_o;
    bus_we_d    = bus_we_o;
    bus_sel_d   = bus_sel_o;
    bus_addr_d  = bus_addr_o;
    bus_wdata_d = bus_wdata_o;
    wb_we_d     = 1'b0;
    wb_waddr_d  = wb_waddr_o;
    wb_wdata_d  = wb_wdata_o;
    exc_d       = 2'd0;
    exc_addr_d  = exc_addr_o;
    if (flush_i) llbit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && dec_legal && !flush_i) begin
          if (misal) begin
            exc_d      = dec_store ? 2'd2 : 2'd1;
            exc_addr_d = addr_i;
          end else if (dec_sc && !(llbit_q && resv_match)) begin
            state_d    = DONE;
            wb_we_d    = 1'b1;
            wb_waddr_d = waddr_i;
            wb_wdata_d = '0;
          end else begin
            state_d     = REQ;
            size_d      = dec_size;
            signed_d    = dec_signed;
            wr_d        = dec_load | dec_sc;
            ll_d        = dec_ll;
            sc_d        = dec_sc;
            flushed_d   = 1'b0;
            addr_d      = addr_i;
            waddr_d     = waddr_i;
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = dec_store;
            bus_sel_d   = sel;
            bus_addr_d  = addr_i & ~ADDR_W'(LANES - 1);
            bus_wdata_d = dec_store ? rep : '0;
            if (dec_store && resv_match) llbit_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (cnt_q == TO_LAST || bus_gnt_i || flush_i) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_sel_d   = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end
        if (cnt_q == TO_LAST) begin
          state_d    = IDLE;
          exc_d      = 2'd3;
          exc_addr_d = addr_q;
        end else if (bus_gnt_i) begin
          state_d   = WAIT;
          flushed_d = flush_i;
          cnt_d     = cnt_q + 8'd1;
        end else if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (flush_i) flushed_d = 1'b1;
        if (cnt_q == TO_LAST) begin
          state_d    = IDLE;
          exc_d      = 2'd3;
          exc_addr_d = addr_q;
        end else if (bus_rvalid_i) begin
          state_d    = DONE;
          wb_we_d    = wr_q && !flushed_q && !flush_i;
          wb_waddr_d = waddr_q;
          wb_wdata_d = sc_q ? DATA_W'(1) : ext;
          if (ll_q && !flushed_q && !flush_i) begin
            llbit_d = 1'b1;
            resv_d  = addr_q[ADDR_W-1:2];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      wr_q        <= 1'b0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;
      flushed_q   <= 1'b0;
      addr_q      <= '0;
      waddr_q     <= 5'd0;
      cnt_q       <= 8'd0;
      llbit_q     <= 1'b0;
      resv_q      <= '0;
      stall_o     <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      wb_we_o     <= 1'b0;
      wb_waddr_o  <= 5'd0;
      wb_wdata_o  <= '0;
      exc_o       <= 2'd0;
      exc_addr_o  <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wr_q        <= wr_d;
      ll_q        <= ll_d;
      sc_q        <= sc_d;
      flushed_q   <= flushed_d;
      addr_q      <= addr_d;
      waddr_q     <= waddr_d;
      cnt_q       <= cnt_d;
      llbit_q     <= llbit_d;
      resv_q      <= resv_d;
      stall_o     <= stall_d;
      bus_req_o   <= bus_req_d;
      bus_we_o    <= bus_we_d;
      bus_sel_o   <= bus_sel_d;
      bus_addr_o  <= bus_addr_d;
      bus_wdata_o <= bus_wdata_d;
      wb_we_o     <= wb_we_d;
      wb_waddr_o  <= wb_waddr_d;
      wb_wdata_o  <= wb_wdata_d;
      exc_o       <= exc_d;
      exc_addr_o  <= exc_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit unit, a 32-bit unit with TIMEOUT=4,
// and a 64-bit unit sharing control/bus inputs but with separate valid strobes.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [4:0]  waddr;
  logic        flush, gnt, rvalid;
  logic        valid_a, valid_t, valid_w;
  logic [31:0] wdata32, rdata32;
  logic [63:0] wdata64, rdata64;

  logic        stall_a, req_a, we_a, wbwe_a;
  logic [3:0]  sel_a;
  logic [31:0] baddr_a, bwdata_a, wbdata_a, excaddr_a;
  logic [4:0]  wbaddr_a;
  logic [1:0]  exc_a;

  logic        stall_t, req_t, we_t, wbwe_t;
  logic [3:0]  sel_t;
  logic [31:0] baddr_t, bwdata_t, wbdata_t, excaddr_t;
  logic [4:0]  wbaddr_t;
  logic [1:0]  exc_t;

  logic        stall_w, req_w, we_w, wbwe_w;
  logic [7:0]  sel_w;
  logic [31:0] baddr_w, excaddr_w;
  logic [63:0] bwdata_w, wbdata_w;
  logic [4:0]  wbaddr_w;
  logic [1:0]  exc_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_a), .op_i(op), .addr_i(addr), .wdata_i(wdata32),
    .waddr_i(waddr), .flush_i(flush), .stall_o(stall_a), .bus_req_o(req_a), .bus_we_o(we_a),
    .bus_sel_o(sel_a), .bus_addr_o(baddr_a), .bus_wdata_o(bwdata_a), .bus_gnt_i(gnt),
    .bus_rvalid_i(rvalid), .bus_rdata_i(rdata32), .wb_we_o(wbwe_a), .wb_waddr_o(wbaddr_a),
    .wb_wdata_o(wbdata_a), .exc_o(exc_a), .exc_addr_o(excaddr_a));

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .valid_i(valid_t), .op_i(op), .addr_i(addr), .wdata_i(wdata32),
    .waddr_i(waddr), .flush_i(flush), .stall_o(stall_t), .bus_req_o(req_t), .bus_we_o(we_t),
    .bus_sel_o(sel_t), .bus_addr_o(baddr_t), .bus_wdata_o(bwdata_t), .bus_gnt_i(gnt),
    .bus_rvalid_i(rvalid), .bus_rdata_i(rdata32), .wb_we_o(wbwe_t), .wb_waddr_o(wbaddr_t),
    .wb_wdata_o(wbdata_t), .exc_o(exc_t), .exc_addr_o(excaddr_t));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut_w (
    .clk(clk), .rst(rst), .valid_i(valid_w), .op_i(op), .addr_i(addr), .wdata_i(wdata64),
    .waddr_i(waddr), .flush_i(flush), .stall_o(stall_w), .bus_req_o(req_w), .bus_we_o(we_w),
    .bus_sel_o(sel_w), .bus_addr_o(baddr_w), .bus_wdata_o(bwdata_w), .bus_gnt_i(gnt),
    .bus_rvalid_i(rvalid), .bus_rdata_i(rdata64), .wb_we_o(wbwe_w), .wb_waddr_o(wbaddr_w),
    .wb_wdata_o(wbdata_w), .exc_o(exc_w), .exc_addr_o(excaddr_w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; op = 4'd0; addr = '0; waddr = '0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    valid_a = 1'b0; valid_t = 1'b0; valid_w = 1'b0;
    wdata32 = '0; rdata32 = '0; wdata64 = '0; rdata64 = '0;
    tick(); tick();
    chk("rst_stall", 64'(stall_a), 64'd0);
    chk("rst_req", 64'(req_a), 64'd0);
    chk("rst_sel", 64'(sel_a), 64'd0);
    chk("rst_wbwe", 64'(wbwe_a), 64'd0);
    chk("rst_exc", 64'(exc_a), 64'd0);
    chk("rst_w_stall", 64'(stall_w), 64'd0);
    chk("rst_t_req", 64'(req_t), 64'd0);
    rst = 1'b0;
    tick();

    // LB 0x101, minimum latency
    valid_a = 1'b1; op = 4'd1; addr = 32'h101; waddr = 5'd5;
    chk("lb_accept_stall", 64'(stall_a), 64'd0);
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("lb_req", 64'(req_a), 64'd1);
    chk("lb_sel", 64'(sel_a), 64'b0100);
    chk("lb_baddr", 64'(baddr_a), 64'h100);
    chk("lb_we", 64'(we_a), 64'd0);
    chk("lb_stall1", 64'(stall_a), 64'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("lb_req_drop", 64'(req_a), 64'd0);
    rvalid = 1'b1; rdata32 = 32'h1280_3456;
    tick();
    rvalid = 1'b0;
    chk("lb_wbwe", 64'(wbwe_a), 64'd1);
    chk("lb_wbdata", 64'(wbdata_a), 64'hFFFF_FF80);
    chk("lb_wbaddr", 64'(wbaddr_a), 64'd5);
    chk("lb_stall3", 64'(stall_a), 64'd1);
    tick();
    chk("lb_wbwe_off", 64'(wbwe_a), 64'd0);
    chk("lb_stall_off", 64'(stall_a), 64'd0);

    // SH 0x202 with grant delayed two cycles
    valid_a = 1'b1; op = 4'd9; addr = 32'h202; wdata32 = 32'h0000_ABCD; waddr = 5'd0;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("sh_sel", 64'(sel_a), 64'b0011);
    chk("sh_wdata", 64'(bwdata_a), 64'hABCD_ABCD);
    chk("sh_we", 64'(we_a), 64'd1);
    chk("sh_stall1", 64'(stall_a), 64'd1);
    tick();
    chk("sh_req_hold", 64'(req_a), 64'd1);
    chk("sh_stall2", 64'(stall_a), 64'd1);
    tick();
    chk("sh_sel_hold", 64'(sel_a), 64'b0011);
    chk("sh_stall3", 64'(stall_a), 64'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sh_stall4", 64'(stall_a), 64'd1);
    chk("sh_req_drop", 64'(req_a), 64'd0);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("sh_stall5", 64'(stall_a), 64'd1);
    chk("sh_no_wb", 64'(wbwe_a), 64'd0);
    tick();
    chk("sh_stall6", 64'(stall_a), 64'd0);

    // Misaligned LW 0x103
    valid_a = 1'b1; op = 4'd5; addr = 32'h103;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("mis_exc", 64'(exc_a), 64'd1);
    chk("mis_exc_addr", 64'(excaddr_a), 64'h103);
    chk("mis_req", 64'(req_a), 64'd0);
    chk("mis_stall", 64'(stall_a), 64'd0);
    tick();
    chk("mis_exc_pulse", 64'(exc_a), 64'd0);
    chk("mis_req2", 64'(req_a), 64'd0);

    // Misaligned SW 0x302
    valid_a = 1'b1; op = 4'd10; addr = 32'h302;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("mis_st_exc", 64'(exc_a), 64'd2);

    // LD is illegal on a 32-bit bus
    valid_a = 1'b1; op = 4'd7; addr = 32'h0;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("ld32_req", 64'(req_a), 64'd0);
    chk("ld32_stall", 64'(stall_a), 64'd0);
    chk("ld32_exc", 64'(exc_a), 64'd0);

    // LL 0x400 then SC 0x400 (success) then SC 0x400 (fail)
    valid_a = 1'b1; op = 4'd12; addr = 32'h400; waddr = 5'd7;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("ll_sel", 64'(sel_a), 64'b1111);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata32 = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    chk("ll_wbdata", 64'(wbdata_a), 64'hDEAD_BEEF);
    chk("ll_wbwe", 64'(wbwe_a), 64'd1);
    tick();
    valid_a = 1'b1; op = 4'd13; addr = 32'h400; wdata32 = 32'h55; waddr = 5'd8;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("sc1_req", 64'(req_a), 64'd1);
    chk("sc1_we", 64'(we_a), 64'd1);
    chk("sc1_wdata", 64'(bwdata_a), 64'h55);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("sc1_wbwe", 64'(wbwe_a), 64'd1);
    chk("sc1_wbdata", 64'(wbdata_a), 64'd1);
    chk("sc1_wbaddr", 64'(wbaddr_a), 64'd8);
    tick();
    valid_a = 1'b1; op = 4'd13; addr = 32'h400; waddr = 5'd9;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("sc2_req", 64'(req_a), 64'd0);
    chk("sc2_stall", 64'(stall_a), 64'd1);
    chk("sc2_wbwe", 64'(wbwe_a), 64'd1);
    chk("sc2_wbdata", 64'(wbdata_a), 64'd0);
    tick();
    chk("sc2_idle", 64'(stall_a), 64'd0);

    // Flush together with rvalid suppresses writeback
    valid_a = 1'b1; op = 4'd5; addr = 32'h500; waddr = 5'd3;
    tick();
    valid_a = 1'b0; op = 4'd0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; flush = 1'b1; rdata32 = 32'h1111_1111;
    tick();
    rvalid = 1'b0; flush = 1'b0;
    chk("fl_wait_wbwe", 64'(wbwe_a), 64'd0);
    chk("fl_wait_stall", 64'(stall_a), 64'd1);
    tick();
    chk("fl_wait_idle", 64'(stall_a), 64'd0);

    // Flush in REQ before grant aborts
    valid_a = 1'b1; op = 4'd5; addr = 32'h504;
    tick();
    valid_a = 1'b0; op = 4'd0;
    chk("fl_req_req", 64'(req_a), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_drop", 64'(req_a), 64'd0);
    chk("fl_req_stall", 64'(stall_a), 64'd0);

    // Timeout with TIMEOUT=4: grant given, rvalid withheld
    valid_t = 1'b1; op = 4'd5; addr = 32'h600;
    tick();
    valid_t = 1'b0; op = 4'd0; gnt = 1'b1;
    chk("to_req", 64'(req_t), 64'd1);
    tick();
    gnt = 1'b0;
    tick();
    tick();
    chk("to_not_yet", 64'(exc_t), 64'd0);
    chk("to_stall4", 64'(stall_t), 64'd1);
    tick();
    chk("to_exc", 64'(exc_t), 64'd3);
    chk("to_exc_addr", 64'(excaddr_t), 64'h600);
    chk("to_idle", 64'(stall_t), 64'd0);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("to_late_rvalid", 64'(wbwe_t), 64'd0);
    chk("to_exc_pulse", 64'(exc_t), 64'd0);

    // 64-bit LWU and LW at 0x104
    valid_w = 1'b1; op = 4'd6; addr = 32'h104; waddr = 5'd2;
    tick();
    valid_w = 1'b0; op = 4'd0;
    chk("lwu_sel", 64'(sel_w), 64'b0000_1111);
    chk("lwu_baddr", 64'(baddr_w), 64'h100);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata64 = 64'h0000_0000_8000_0001;
    tick();
    rvalid = 1'b0;
    chk("lwu_wbdata", wbdata_w, 64'h0000_0000_8000_0001);
    chk("lwu_wbwe", 64'(wbwe_w), 64'd1);
    tick();
    valid_w = 1'b1; op = 4'd5; addr = 32'h104;
    tick();
    valid_w = 1'b0; op = 4'd0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("lw64_wbdata", wbdata_w, 64'hFFFF_FFFF_8000_0001);
    tick();

    // 64-bit SB at 0x107 replicates the byte and picks the LSB lane
    valid_w = 1'b1; op = 4'd8; addr = 32'h107; wdata64 = 64'h0000_0000_0000_00A5;
    tick();
    valid_w = 1'b0; op = 4'd0;
    chk("sb64_sel", 64'(sel_w), 64'b0000_0001);
    chk("sb64_wdata", bwdata_w, 64'hA5A5_A5A5_A5A5_A5A5);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("sb64_no_wb", 64'(wbwe_w), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
